// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared binary32 constants, state type and helpers for the square-root unit
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int ROOT_W   = 25;
    localparam int RAD_W    = 50;
    localparam int REM_W    = 28;
    localparam int ITER_N   = 25;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_ITER,
        S_ROUND
    } state_t;

    // Highest set bit wins because the scan runs from LSB upwards.
    function automatic logic [4:0] lzc24(input logic [MANT_W-1:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < MANT_W; i++) begin
            if (v[i]) n = 5'(MANT_W - 1 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_sqrt_if.sv
// rtl/fp32_sqrt_if.sv - request/result bundle between the FPU issue logic and fp32_sqrt
interface fp32_sqrt_if;
    logic        start;
    logic [31:0] A;
    logic        done;
    logic [31:0] result;
    logic        exception;
    logic        zero_sqrt;

    modport master (output start, A, input done, result, exception, zero_sqrt);
    modport slave  (input start, A, output done, result, exception, zero_sqrt);
endinterface

// File: rtl/fp32_sqrt_core.sv
// rtl/fp32_sqrt_core.sv - restoring integer square root, one root bit per step
module fp32_sqrt_core
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [RAD_W-1:0]  radicand,
    output logic [ROOT_W-1:0] q,
    output logic [REM_W-1:0]  rem,
    output logic              busy,
    output logic              last
);

    logic [RAD_W-1:0] rad;
    logic [4:0]       cnt;
    logic [REM_W-1:0] rem_sh;
    logic [REM_W:0]   trial;
    logic             fits;

    // Before each step rem <= 2*q < 2^25, so the two dropped MSBs are always zero.
    assign rem_sh = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
    assign trial  = {1'b0, rem_sh} - {{(REM_W - ROOT_W - 1){1'b0}}, q, 2'b01};
    assign fits   = !trial[REM_W];
    assign busy   = (cnt != 5'd0);
    assign last   = (cnt == 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rad <= '0;
            q   <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (load) begin
            rad <= radicand;
            q   <= '0;
            rem <= '0;
            cnt <= 5'(ITER_N);
        end else if (step && busy) begin
            rad <= {rad[RAD_W-3:0], 2'b00};
            q   <= {q[ROOT_W-2:0], fits};
            rem <= fits ? trial[REM_W-1:0] : rem_sh;
            cnt <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/fp32_sqrt.sv
// rtl/fp32_sqrt.sv - multi-cycle binary32 square root, RNE; SQRT_SUBNORMAL_EN normalizes subnormal inputs
module fp32_sqrt
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    fp32_sqrt_if.slave  bus
);

    state_t            state;
    logic [31:0]       a_reg;
    logic              second;
    logic              pend_special;
    logic [31:0]       pend_result;
    logic              pend_exc;
    logic              pend_zero;
    logic [EXP_W-1:0]  res_exp;
    logic              done_r;
    logic [31:0]       result_r;
    logic              exc_r;
    logic              zero_r;

    logic              sign;
    logic [EXP_W-1:0]  e_fld;
    logic [FRAC_W-1:0] frac;
    logic              is_nan, is_inf, is_zero, is_sub;
    logic              special_now, spec_exc, spec_zero, sub_path;
    logic [31:0]       spec_result;

    logic signed [9:0] e_src;
    logic [MANT_W-1:0] m_src;
    logic [ROOT_W-1:0] m25;
    logic [EXP_W-1:0]  exp_field;

    logic              core_load, core_busy, core_last;
    logic [ROOT_W-1:0] core_q;
    logic [REM_W-1:0]  core_rem;
    logic              inc;
    logic [31:0]       round_sum;

    assign sign    = a_reg[31];
    assign e_fld   = a_reg[30:23];
    assign frac    = a_reg[22:0];
    assign is_nan  = (e_fld == 8'hFF) && (frac != '0);
    assign is_inf  = (e_fld == 8'hFF) && (frac == '0);
    assign is_zero = (e_fld == 8'h00) && (frac == '0);
    assign is_sub  = (e_fld == 8'h00) && (frac != '0);

    always_comb begin
        special_now = 1'b1;
        spec_result = CANON_NAN;
        spec_exc    = 1'b1;
        spec_zero   = 1'b0;
        if (is_nan) begin
            spec_exc = 1'b1;
        end else if (sign && !is_zero) begin
            spec_exc = 1'b1;
        end else if (is_zero) begin
            spec_result = {sign, 31'd0};
            spec_exc    = 1'b0;
            spec_zero   = 1'b1;
        end else if (is_inf) begin
            spec_result = POS_INF;
            spec_exc    = 1'b0;
`ifndef SQRT_SUBNORMAL_EN
        end else if (is_sub) begin
            spec_result = {sign, 31'd0};
            spec_exc    = 1'b0;
            spec_zero   = 1'b1;
`endif
        end else begin
            special_now = 1'b0;
            spec_exc    = 1'b0;
        end
    end

`ifdef SQRT_SUBNORMAL_EN
    logic signed [9:0] sub_e;
    logic [MANT_W-1:0] sub_m;
    logic [4:0]        lz;

    assign lz       = lzc24({1'b0, frac});
    assign sub_path = is_sub && !sign;
    assign e_src    = second ? sub_e : ($signed({2'b00, e_fld}) - 10'sd127);
    assign m_src    = second ? sub_m : {1'b1, frac};
`else
    assign sub_path = 1'b0;
    assign e_src    = $signed({2'b00, e_fld}) - 10'sd127;
    assign m_src    = {1'b1, frac};
`endif

    // Odd exponent: double the mantissa; floor(e/2) equals (e-1)/2 for odd e.
    assign m25       = e_src[0] ? {m_src, 1'b0} : {1'b0, m_src};
    assign exp_field = 8'((e_src >>> 1) + 10'sd127);

    assign core_load = (state == S_UNPACK) &&
                       (second ? !pend_special : (!special_now && !sub_path));

    fp32_sqrt_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (state == S_ITER),
        .radicand ({m25, 25'd0}),
        .q        (core_q),
        .rem      (core_rem),
        .busy     (core_busy),
        .last     (core_last)
    );

    // Root MSB is the hidden bit: it adds one to the exponent field, so res_exp is pre-decremented.
    assign inc       = core_q[0] && ((core_rem != '0) || core_q[1]);
    assign round_sum = {1'b0, res_exp - 8'd1, 23'd0} + {8'd0, core_q[ROOT_W-1:1]} + {31'd0, inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            a_reg        <= '0;
            second       <= 1'b0;
            pend_special <= 1'b0;
            pend_result  <= '0;
            pend_exc     <= 1'b0;
            pend_zero    <= 1'b0;
            res_exp      <= '0;
            done_r       <= 1'b0;
            result_r     <= '0;
            exc_r        <= 1'b0;
            zero_r       <= 1'b0;
`ifdef SQRT_SUBNORMAL_EN
            sub_e        <= '0;
            sub_m        <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.A;
                        second <= 1'b0;
                        state  <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (!second) begin
                        if (special_now) begin
                            pend_special <= 1'b1;
                            pend_result  <= spec_result;
                            pend_exc     <= spec_exc;
                            pend_zero    <= spec_zero;
                            second       <= 1'b1;
                        end else if (sub_path) begin
                            pend_special <= 1'b0;
                            second       <= 1'b1;
`ifdef SQRT_SUBNORMAL_EN
                            sub_e        <= -10'sd126 - $signed({5'd0, lz});
                            sub_m        <= {1'b0, frac} << lz;
`endif
                        end else begin
                            res_exp <= exp_field;
                            state   <= S_ITER;
                        end
                    end else if (pend_special) begin
                        done_r   <= 1'b1;
                        result_r <= pend_result;
                        exc_r    <= pend_exc;
                        zero_r   <= pend_zero;
                        state    <= S_IDLE;
                    end else begin
                        res_exp <= exp_field;
                        state   <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (core_last) state <= S_ROUND;
                end
                S_ROUND: begin
                    done_r   <= 1'b1;
                    result_r <= round_sum;
                    exc_r    <= 1'b0;
                    zero_r   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.exception = exc_r;
    assign bus.zero_sqrt = zero_r;

endmodule

// File: tb/tb_fp32_sqrt.sv
// tb/tb_fp32_sqrt.sv - scoreboard bench for fp32_sqrt
module tb_fp32_sqrt;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp32_sqrt_if bus ();
    fp32_sqrt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [31:0] a);
        exp_t        x;
        int          e;
        longint      m, r, lo, hi, mid, q, mant;
        logic [63:0] mv;
        logic [7:0]  ex8;
        x.res = 32'h7FC00000; x.exc = 1'b1; x.zero = 1'b0; x.lat = 2;
        if (a[30:23] == 8'hFF && a[22:0] != 0) begin
            x.exc = 1'b1;
        end else if (a[31] && a[30:0] != 0) begin
            x.exc = 1'b1;
        end else if (a[30:0] == 0) begin
            x.res = a; x.exc = 1'b0; x.zero = 1'b1;
        end else if (a[30:23] == 8'hFF) begin
            x.res = 32'h7F800000; x.exc = 1'b0;
        end else if (a[30:23] == 8'h00) begin
            x.res = {a[31], 31'd0}; x.exc = 1'b0; x.zero = 1'b1;
        end else begin
            x.exc = 1'b0; x.lat = 27;
            e = int'(a[30:23]) - 127;
            m = longint'(24'h800000 | a[22:0]);
            if ((e & 1) != 0) begin m = m << 1; e = e - 1; end
            r  = m << 25;
            lo = 0; hi = longint'(1) << 25;
            while (lo < hi) begin
                mid = (lo + hi + 1) >> 1;
                if (mid * mid <= r) lo = mid; else hi = mid - 1;
            end
            q    = lo;
            mant = q >> 1;
            if ((q & 1) != 0 && ((q * q != r) || (mant & 1) != 0)) mant = mant + 1;
            e = e / 2 + 127;
            if (mant == (longint'(1) << 24)) begin mant = mant >> 1; e = e + 1; end
            mv  = mant;
            ex8 = 8'(e);
            x.res = {1'b0, ex8, mv[22:0]};
        end
        return x;
    endfunction

    task automatic send(input logic [31:0] a, input exp_t x);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        sb.push_back(x);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic collect(output logic [31:0] r, output logic e, output logic z, output int lat);
        lat = -1; r = 'x; e = 1'bx; z = 1'bx;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                r = bus.result; e = bus.exception; z = bus.zero_sqrt; lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.A = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_vec++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 00000000", bus.result); end
        n_vec++; if (bus.exception !== 1'b0) begin n_bad++; $display("FAIL reset_exc got %b want 0", bus.exception); end
        n_vec++; if (bus.zero_sqrt !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", bus.zero_sqrt); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] av[10] = '{32'h40800000, 32'h40000000, 32'h41100000, 32'h3F000000, 32'hC0800000,
                                32'h80000000, 32'h7F800000, 32'h7FA00000, 32'hFF800000, 32'h00000000};
        logic [31:0] rv[10] = '{32'h40000000, 32'h3FB504F3, 32'h40400000, 32'h3F3504F3, 32'h7FC00000,
                                32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
        logic        ev[10] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
        logic        zv[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        int          lv[10] = '{27, 27, 27, 27, 2, 2, 2, 2, 2, 2};
        logic [31:0] r; logic e, z; int lat; exp_t x;
        for (int i = 0; i < 10; i++) begin
            send(av[i], '{res: rv[i], exc: ev[i], zero: zv[i], lat: lv[i]});
            collect(r, e, z, lat);
            x = sb.pop_front();
            n_vec++;
            if ({r, e, z} !== {x.res, x.exc, x.zero}) begin
                n_bad++;
                $display("FAIL directed A=%h got %h/%b/%b want %h/%b/%b", av[i], r, e, z, x.res, x.exc, x.zero);
            end
            n_vec++;
            if (lat !== x.lat) begin n_bad++; $display("FAIL directed_lat A=%h got %0d want %0d", av[i], lat, x.lat); end
        end
`ifndef SQRT_SUBNORMAL_EN
        send(32'h00000001, '{res: 32'h0, exc: 1'b0, zero: 1'b1, lat: 2});
        collect(r, e, z, lat);
        x = sb.pop_front();
        n_vec++;
        if ({r, e, z, lat} !== {x.res, x.exc, x.zero, x.lat}) begin
            n_bad++;
            $display("FAIL subnormal_flush got %h/%b/%b lat %0d want %h/%b/%b lat %0d", r, e, z, lat, x.res, x.exc, x.zero, x.lat);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a, r; logic e, z; int lat; exp_t x;
        for (int i = 0; i < 20; i++) begin
            a = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
            if (i % 5 == 4) a = {1'b1, 8'($urandom_range(254, 1)), 23'($urandom)};
            send(a, model(a));
            collect(r, e, z, lat);
            x = sb.pop_front();
            n_vec++;
            if ({r, e, z, lat} !== {x.res, x.exc, x.zero, x.lat}) begin
                n_bad++;
                $display("FAIL random A=%h got %h/%b/%b lat %0d want %h/%b/%b lat %0d", a, r, e, z, lat, x.res, x.exc, x.zero, x.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av[4] = '{32'h3F800000, 32'h7F7FFFFF, 32'h00800000, 32'h3F7FFFFF};
        logic [31:0] r; logic e, z; int lat; exp_t x;
        for (int i = 0; i < 4; i++) begin
            send(av[i], model(av[i]));
            collect(r, e, z, lat);
            x = sb.pop_front();
            n_vec++;
            if ({r, e, z, lat} !== {x.res, x.exc, x.zero, x.lat}) begin
                n_bad++;
                $display("FAIL b2b A=%h got %h/%b/%b lat %0d want %h/%b/%b lat %0d", av[i], r, e, z, lat, x.res, x.exc, x.zero, x.lat);
            end
        end
    endtask

    task automatic test_busy_start();
        int lat; logic got; exp_t x;
        @(negedge clk);
        bus.start = 1'b1; bus.A = 32'h40800000;
        sb.push_back('{res: 32'h40000000, exc: 1'b0, zero: 1'b0, lat: 27});
        @(negedge clk);
        bus.A = 32'h41100000;
        lat = 0; got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) got = 1'b1;
            if (lat == 20) bus.start = 1'b0;
        end
        x = sb.pop_front();
        n_vec++;
        if (!got || bus.result !== x.res || lat !== x.lat) begin
            n_bad++;
            $display("FAIL busy_start got %h lat %0d want %h lat %0d", bus.result, lat, x.res, x.lat);
        end
        @(posedge clk); #1;
        n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b want 0", bus.done); end
        n_vec++; if (bus.result !== x.res) begin n_bad++; $display("FAIL result_hold got %h want %h", bus.result, x.res); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic e, z; int lat; exp_t x;
        send(32'h41100000, model(32'h41100000));
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        void'(sb.pop_back());
        n_vec++;
        if ({bus.done, bus.result, bus.exception, bus.zero_sqrt} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_mid got done=%b res=%h exc=%b zero=%b want all 0", bus.done, bus.result, bus.exception, bus.zero_sqrt);
        end
        @(negedge clk); rst_n = 1'b1;
        send(32'h41100000, '{res: 32'h40400000, exc: 1'b0, zero: 1'b0, lat: 27});
        collect(r, e, z, lat);
        x = sb.pop_front();
        n_vec++;
        if ({r, e, z, lat} !== {x.res, x.exc, x.zero, x.lat}) begin
            n_bad++;
            $display("FAIL after_reset got %h/%b/%b lat %0d want %h/%b/%b lat %0d", r, e, z, lat, x.res, x.exc, x.zero, x.lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_busy_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
